// File: rtl/rx_pkt_asm.sv
// Receive frame assembler: writes src/dst/len/payload/crc bytes into an external
// frame RAM, checks length and CRC, and holds a good frame via valid/ack.
// Optional destination filtering is enabled by defining RX_FILTER_EN.
module rx_pkt_asm #(
    parameter int MAX_LEN = 253,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_idle,
    input  logic [7:0]        data,
    input  logic              data_clk,
    input  logic [15:0]       crc_data,
    input  logic [7:0]        filt_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] frame_len,
    input  logic              frame_ack,
    input  logic              cnt_clr,
    output logic [7:0]        cnt_crc_err,
    output logic [7:0]        cnt_lost,
    output logic [7:0]        cnt_break
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [7:0]        len, len_nxt;
    logic [ADDR_W:0]   last_idx;
    logic              wr_nxt;
    logic              valid_set;
    logic              inc_crc, inc_lost, inc_break;
    logic              dst_ok;

    function automatic logic [7:0] sat_cnt(input logic [7:0] c, input logic inc,
                                           input logic clr);
        if (clr)
            return 8'h00;
        if (inc && c != 8'hFF)
            return c + 8'd1;
        return c;
    endfunction

`ifdef RX_FILTER_EN
    assign dst_ok = (data == filt_addr) || (data == 8'hFF);
`else
    logic unused_filt;
    assign unused_filt = ^filt_addr;
    assign dst_ok      = 1'b1;
`endif

    // Index of crc_h; len is already latched whenever idx can reach this value.
    assign last_idx = (ADDR_W+1)'(len) + (ADDR_W+1)'(4);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        wr_nxt    = 1'b0;
        valid_set = 1'b0;
        inc_crc   = 1'b0;
        inc_lost  = 1'b0;
        inc_break = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (bus_idle)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (data_clk) begin
                    if (frame_valid && !frame_ack) begin
                        inc_lost  = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        wr_nxt    = 1'b1;
                        idx_nxt   = ADDR_W'(1);
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (data_clk) begin
                    wr_nxt  = 1'b1;
                    idx_nxt = idx + 1'b1;
                    if (idx == ADDR_W'(2))
                        len_nxt = data;
                    if (idx == ADDR_W'(1) && !dst_ok) begin
                        state_nxt = DROP;
                    end else if (idx == ADDR_W'(2) && data > 8'(MAX_LEN)) begin
                        inc_break = 1'b1;
                        state_nxt = DROP;
                    end else if ({1'b0, idx} == last_idx) begin
                        if (crc_data == 16'h0000)
                            valid_set = 1'b1;
                        else
                            inc_crc = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else if (bus_idle) begin
                        inc_break = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (bus_idle) begin
                    inc_break = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (bus_idle)
                    state_nxt = IDLE;
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // Datapath registers carry no reset; only control and outputs do.
    always_ff @(posedge clk) begin
        idx <= idx_nxt;
        len <= len_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            cnt_crc_err <= 8'h00;
            cnt_lost    <= 8'h00;
            cnt_break   <= 8'h00;
        end else begin
            state   <= state_nxt;
            wr_en   <= wr_nxt;
            wr_addr <= (state == RECV) ? idx : '0;
            wr_data <= data;
            if (valid_set) begin
                frame_valid <= 1'b1;
                frame_len   <= ADDR_W'(len) + ADDR_W'(3);
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
            cnt_crc_err <= sat_cnt(cnt_crc_err, inc_crc, cnt_clr);
            cnt_lost    <= sat_cnt(cnt_lost, inc_lost, cnt_clr);
            cnt_break   <= sat_cnt(cnt_break, inc_break, cnt_clr);
        end
    end

endmodule

// File: tb/tb_rx_pkt_asm.sv
// Randomized bench for rx_pkt_asm: frames with real CRC-16 are fed in and each
// outcome is predicted at frame level (accepted, lost, broken, bad CRC, filtered).
module tb_rx_pkt_asm;

    localparam int MAX_LEN = 253;
    localparam int ADDR_W  = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              bus_idle = 1'b0;
    logic [7:0]        data = 8'h00;
    logic              data_clk = 1'b0;
    logic [15:0]       crc_data = 16'hFFFF;
    logic [7:0]        filt_addr = 8'h02;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_valid;
    logic [ADDR_W-1:0] frame_len;
    logic              frame_ack = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [7:0]        cnt_crc_err, cnt_lost, cnt_break;

    rx_pkt_asm #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .bus_idle(bus_idle), .data(data),
        .data_clk(data_clk), .crc_data(crc_data), .filt_addr(filt_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
        .cnt_clr(cnt_clr), .cnt_crc_err(cnt_crc_err), .cnt_lost(cnt_lost),
        .cnt_break(cnt_break)
    );

    always #5 clk = ~clk;

    // External frame RAM plus a running count of write strobes.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    int         wr_cnt = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            ram[wr_addr] = wr_data;
            wr_cnt++;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference state, kept at frame level.
    bit         m_valid = 0;
    int         m_len = 0;
    int         m_crc = 0, m_lost = 0, m_brk = 0;
    logic [7:0] snap [$];
    logic [7:0] fb [$];
    logic [15:0] crc_run = 16'hFFFF;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        bus_idle = 1'b1;
        crc_run  = 16'hFFFF;
        crc_data = crc_run;
        repeat (3) tick();
        bus_idle = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack, input bit idl);
        data      = b;
        crc_run   = crc_upd(crc_run, b);
        crc_data  = crc_run;
        data_clk  = 1'b1;
        frame_ack = ack;
        bus_idle  = idl;
        tick();
        data_clk  = 1'b0;
        frame_ack = 1'b0;
        if (!idl)
            repeat ($urandom_range(0, 2)) tick();
    endtask

    // Header + payload must already be in fb; appends crc_l, crc_h.
    task automatic finish_frame(input bit corrupt);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (fb[i]) c = crc_upd(c, fb[i]);
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
        if (corrupt)
            fb[fb.size()-2] = fb[fb.size()-2] ^ 8'(1 << $urandom_range(0, 7));
    endtask

    task automatic rand_frame(input logic [7:0] dst, input int len, input bit corrupt);
        fb.delete();
        fb.push_back(8'($urandom));
        fb.push_back(dst);
        fb.push_back(8'(len));
        if (len <= MAX_LEN)
            for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        else
            for (int i = 0; i < 4; i++) fb.push_back(8'($urandom));
        finish_frame(corrupt);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        m_valid = 0;
        tick();
        chk("ack_clear", frame_valid, 1'b0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, frame_valid, m_valid);
        if (m_valid)
            chk({tag, "_len"}, frame_len, m_len);
        chk({tag, "_crc"}, cnt_crc_err, m_crc);
        chk({tag, "_lost"}, cnt_lost, m_lost);
        chk({tag, "_brk"}, cnt_break, m_brk);
    endtask

    task automatic run_frame(input string tag, input int nsend, input bit corrupt,
                             input bit ack_first, input bit idle_last);
        int  len, ew, w0;
        bit  ack_now, accepted, dst_pass, new_valid, same;
        len       = int'(fb[2]);
        ack_now   = ack_first && m_valid;
        accepted  = !m_valid || ack_now;
        new_valid = 0;
`ifdef RX_FILTER_EN
        dst_pass = (fb[1] == filt_addr) || (fb[1] == 8'hFF);
`else
        dst_pass = 1;
`endif
        if (ack_now)
            m_valid = 0;
        if (!accepted) begin
            m_lost = sat(m_lost); ew = 0;
        end else if (nsend >= 2 && !dst_pass) begin
            ew = 2;
        end else if (nsend >= 3 && len > MAX_LEN) begin
            m_brk = sat(m_brk); ew = 3;
        end else if (nsend < len + 5) begin
            m_brk = sat(m_brk); ew = nsend;
        end else if (!corrupt) begin
            m_valid = 1; m_len = len + 3; snap = fb; new_valid = 1; ew = len + 5;
        end else begin
            m_crc = sat(m_crc); ew = len + 5;
        end
        w0 = wr_cnt;
        for (int i = 0; i < nsend; i++)
            send_byte(fb[i], ack_now && i == 0, idle_last && i == nsend - 1);
        idle_gap();
        check_state(tag);
        chk({tag, "_writes"}, wr_cnt - w0, ew);
        if (m_valid) begin
            same = 1;
            for (int i = 0; i < (new_valid ? snap.size() : m_len); i++)
                if (ram[i] !== snap[i]) same = 0;
            chk({tag, "_ram"}, same, 1'b1);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_len", frame_len, 0);
        chk("rst_cnts", {cnt_crc_err, cnt_lost, cnt_break}, 0);
        reset = 1'b0;
        idle_gap();

        // Reset in the middle of a frame discards it without counting.
        rand_frame(8'h02, 6, 0);
        for (int i = 0; i < 4; i++) send_byte(fb[i], 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_gap();
        check_state("midrst");

        fb = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        finish_frame(0);
        run_frame("basic", 8, 0, 0, 0);
        do_ack();

        fb = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        finish_frame(1);
        run_frame("badcrc", 8, 1, 0, 0);

        rand_frame(8'h02, 4, 0);
        run_frame("held", 9, 0, 0, 0);
        rand_frame(8'h02, 5, 0);
        run_frame("lost", 10, 0, 0, 0);
        do_ack();
        rand_frame(8'h02, 3, 0);
        run_frame("after_ack", 8, 0, 0, 0);
        do_ack();

        rand_frame(8'h02, 5, 0);
        run_frame("trunc", 3, 0, 0, 0);
        rand_frame(8'h02, 254, 0);
        run_frame("toolong", 7, 0, 0, 0);
        rand_frame(8'hFF, 2, 0);
        run_frame("bcast", 7, 0, 0, 1);
        rand_frame(8'h03, 2, 0);
        run_frame("otherdst", 7, 0, 1, 0);

        for (int f = 0; f < 60; f++) begin
            int         len, nsend;
            bit         corrupt;
            logic [7:0] dst;
            if (m_valid && $urandom_range(0, 2) == 0)
                do_ack();
            case ($urandom_range(0, 3))
                0: dst = 8'h02;
                1: dst = 8'hFF;
                2: dst = 8'h03;
                default: dst = 8'($urandom);
            endcase
            len     = ($urandom_range(0, 9) == 0) ? 254 + $urandom_range(0, 1)
                                                 : $urandom_range(0, 12);
            corrupt = ($urandom_range(0, 3) == 0);
            rand_frame(dst, len, corrupt);
            if (len > MAX_LEN)
                nsend = $urandom_range(1, 7);
            else if ($urandom_range(0, 5) == 0)
                nsend = $urandom_range(1, len + 4);
            else
                nsend = len + 5;
            run_frame("rand", nsend, corrupt, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0);
        end

        // Lost-frame counter saturation while a frame is held.
        if (!m_valid) begin
            rand_frame(8'h02, 1, 0);
            run_frame("hold2", 6, 0, 0, 0);
        end
        for (int f = 0; f < 258; f++) begin
            rand_frame(8'h02, 0, 0);
            run_frame("sat", 1, 0, 0, 0);
        end
        chk("sat_lost", cnt_lost, 8'hFF);

        // Clear coinciding with a lost-frame increment wins.
        data     = 8'h11;
        data_clk = 1'b1;
        cnt_clr  = 1'b1;
        tick();
        data_clk = 1'b0;
        cnt_clr  = 1'b0;
        idle_gap();
        m_crc = 0; m_lost = 0; m_brk = 0;
        check_state("clr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
